picomips_sequencer: RTL and testbench

//  Parametrised multi-cycle control unit for picoMips: registered instruction decode plus stage FSM.

---
 rtl/picomips_sequencer.sv | 120 ++++++++++++
 tb/tb_picomips_sequencer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/picomips_sequencer.sv
// picoMips multi-cycle control unit: registered instruction decode, stage FSM,
// and a debounced handshake wait for the halt-until-handshake (HEI) instruction.
module picomips_sequencer #(
  parameter int IW      = 10,
  parameter int DW      = 8,
  parameter int IMMW    = 4,
  parameter int DEB_CYC = 4
) (
  input  logic          clk,
  input  logic          nReset,
  input  logic [IW-1:0] Instruction,
  input  logic          Handshake,
  output logic [1:0]    Stage,
  output logic [DW-1:0] Immediate,
  output logic          PCInc,
  output logic          PCHold,
  output logic          RegWrite,
  output logic          ACCWE,
  output logic          RegAddr,
  output logic          SelImm,
  output logic          SelSW,
  output logic          UseMul,
  output logic          UseA,
  output logic          SelReg
);

  localparam int CW = $clog2(DEB_CYC + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_WAIT   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic [5:0]      ctrl_q, ctrl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            hs_meta_q, hs_sync_q;
  logic [5:0]      func;
  logic            match;

  assign func      = ir_q[IW-1 -: 6];
  assign match     = (hs_sync_q == ir_q[0]);
  assign Immediate = {{(DW-IMMW){ir_q[IMMW-1]}}, ir_q[IMMW-1:0]};
  assign RegAddr   = ir_q[0];
  assign UseA      = ctrl_q[0];
  assign SelSW     = ctrl_q[1];
  assign SelImm    = ctrl_q[2];
  assign UseMul    = ctrl_q[3];
  assign SelReg    = ctrl_q[5];

  always_comb begin
    state_d  = state_q;
    ir_d     = ir_q;
    ctrl_d   = ctrl_q;
    cnt_d    = '0;
    Stage    = 2'd0;
    PCInc    = 1'b0;
    PCHold   = 1'b0;
    ACCWE    = 1'b0;
    RegWrite = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_d    = Instruction;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        Stage   = 2'd1;
        ctrl_d  = func;
        state_d = (func[5] & func[2]) ? S_WAIT : S_EXEC;
      end
      S_EXEC: begin
        Stage   = 2'd2;
        ACCWE   = 1'b1;
        state_d = S_WB;
      end
      S_WB: begin
        Stage    = 2'd3;
        RegWrite = ctrl_q[4];
        PCInc    = 1'b1;
        state_d  = S_FETCH;
      end
      S_WAIT: begin
        Stage = 2'd3;
        // cnt_q counts matches in earlier cycles; this cycle's match completes the run
        if (match)
          cnt_d = (cnt_q == CW'(DEB_CYC)) ? cnt_q : cnt_q + CW'(1);
        if (match && cnt_q == CW'(DEB_CYC - 1)) begin
          PCInc   = 1'b1;
          state_d = S_FETCH;
        end else begin
          PCHold  = 1'b1;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      hs_meta_q <= 1'b0;
      hs_sync_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
      hs_meta_q <= Handshake;
      hs_sync_q <= hs_meta_q;
    end
  end

endmodule

// File: tb/tb_picomips_sequencer.sv
// Bench for picomips_sequencer: directed and random instructions on a default
// build and a wide (IW=12, DW=16) build, against a per-instruction timeline model.
module tb_picomips_sequencer;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [9:0]  Instruction = '0;
  logic        Handshake = 1'b0;
  logic [1:0]  Stage;
  logic [7:0]  Immediate;
  logic        PCInc, PCHold, RegWrite, ACCWE, RegAddr, SelImm, SelSW, UseMul, UseA, SelReg;

  logic [11:0] ins2 = '0;
  logic        hs2 = 1'b0;
  logic [1:0]  st2;
  logic [15:0] imm2;
  logic        pci2, pch2, rw2, acc2, ra2, simm2, ssw2, umul2, usea2, sreg2;

  int n_tests = 0;
  int n_fail  = 0;
  logic h1 = 1'b0, h2 = 1'b0;   // Handshake as seen at the last two clock edges
  bit   hs_q[$];

  always #5 clk = ~clk;

  picomips_sequencer #(.IW(10), .DW(8), .IMMW(4), .DEB_CYC(DEB)) dut (
    .clk(clk), .nReset(nReset), .Instruction(Instruction), .Handshake(Handshake),
    .Stage(Stage), .Immediate(Immediate), .PCInc(PCInc), .PCHold(PCHold),
    .RegWrite(RegWrite), .ACCWE(ACCWE), .RegAddr(RegAddr), .SelImm(SelImm),
    .SelSW(SelSW), .UseMul(UseMul), .UseA(UseA), .SelReg(SelReg));

  picomips_sequencer #(.IW(12), .DW(16), .IMMW(4), .DEB_CYC(DEB)) dut_w (
    .clk(clk), .nReset(nReset), .Instruction(ins2), .Handshake(hs2),
    .Stage(st2), .Immediate(imm2), .PCInc(pci2), .PCHold(pch2),
    .RegWrite(rw2), .ACCWE(acc2), .RegAddr(ra2), .SelImm(simm2),
    .SelSW(ssw2), .UseMul(umul2), .UseA(usea2), .SelReg(sreg2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    h2 = h1;
    h1 = Handshake;
    @(posedge clk);
    #1;
  endtask

  task automatic hs_next();
    if (hs_q.size() > 0) Handshake = hs_q.pop_front();
  endtask

  // expected select vector {SelReg,UseMul,SelImm,SelSW,UseA} from func bits
  function automatic logic [4:0] sel_of(input logic [5:0] f);
    return {f[5], f[3], f[2], f[1], f[0]};
  endfunction

  task automatic run1(input logic [9:0] ins);
    logic [5:0] f   = ins[9:4];
    logic [7:0] imm = {{4{ins[3]}}, ins[3:0]};
    int  run = 0;
    bit  rel = 0;
    int  guard = 0;
    check("fetch_stage", Stage, 0);
    check("fetch_strobes", {PCInc, PCHold, ACCWE, RegWrite}, 0);
    Instruction = ins;
    hs_next(); step();
    check("dec_stage", Stage, 1);
    check("dec_imm", Immediate, imm);
    check("dec_regaddr", RegAddr, ins[0]);
    check("dec_strobes", {PCInc, PCHold, ACCWE, RegWrite}, 0);
    hs_next(); step();
    if (f[5] && f[2]) begin
      while (!rel && guard < 300) begin
        run = (h2 == ins[0]) ? run + 1 : 0;
        rel = (run >= DEB);
        check("wait_stage", Stage, 3);
        check("wait_pcinc", PCInc, rel);
        check("wait_pchold", PCHold, !rel);
        check("wait_we", {ACCWE, RegWrite}, 0);
        check("wait_sel", {SelReg, UseMul, SelImm, SelSW, UseA}, sel_of(f));
        hs_next(); step();
        guard++;
      end
      check("wait_release", rel, 1);
    end else begin
      check("exec_stage", Stage, 2);
      check("exec_strobes", {ACCWE, RegWrite, PCInc, PCHold}, 4'b1000);
      check("exec_sel", {SelReg, UseMul, SelImm, SelSW, UseA}, sel_of(f));
      hs_next(); step();
      check("wb_stage", Stage, 3);
      check("wb_strobes", {ACCWE, RegWrite, PCInc, PCHold}, {1'b0, f[4], 2'b10});
      check("wb_sel", {SelReg, UseMul, SelImm, SelSW, UseA}, sel_of(f));
      check("wb_imm", Immediate, imm);
      hs_next(); step();
    end
  endtask

  // Both builds run one non-HEI instruction each in lock-step
  task automatic run_pair(input logic [9:0] a, input logic [11:0] b, inout int pc_a, inout int pc_b);
    logic [5:0]  fa = a[9:4];
    logic [5:0]  fb = b[11:6];
    logic [15:0] ib = {{12{b[3]}}, b[3:0]};
    Instruction = a;
    ins2 = b;
    for (int k = 0; k < 4; k++) begin
      check("p_stage", Stage, k);
      check("pw_stage", st2, k);
      check("p_strobes", {ACCWE, RegWrite, PCInc, PCHold}, {k == 2, (k == 3) && fa[4], k == 3, 1'b0});
      check("pw_strobes", {acc2, rw2, pci2, pch2}, {k == 2, (k == 3) && fb[4], k == 3, 1'b0});
      pc_a += PCInc;
      pc_b += pci2;
      if (k >= 1) begin
        check("pw_imm", imm2, ib);
        check("pw_regaddr", ra2, b[0]);
      end
      if (k >= 2) begin
        check("p_sel", {SelReg, UseMul, SelImm, SelSW, UseA}, sel_of(fa));
        check("pw_sel", {sreg2, umul2, simm2, ssw2, usea2}, sel_of(fb));
      end
      step();
    end
  endtask

  task automatic check_reset_outs();
    check("rst_outs", {Stage, Immediate, PCInc, PCHold, RegWrite, ACCWE, RegAddr,
                       SelImm, SelSW, UseMul, UseA, SelReg}, 0);
    check("rst_outs_w", {st2, imm2, pci2, pch2, rw2, acc2, ra2,
                         simm2, ssw2, umul2, usea2, sreg2}, 0);
  endtask

  // Assert reset between edges, check outputs cleared before the next edge, release at negedge
  task automatic do_reset();
    #2 nReset = 1'b0;
    #1 check_reset_outs();
    @(negedge clk);
    nReset = 1'b1;
    Handshake = 1'b0;
    hs_q.delete();
    h1 = 1'b0;
    h2 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pc_a, pc_b, n_pair;
    logic [9:0]  a;
    logic [11:0] b;
    repeat (3) @(posedge clk);
    #1 check_reset_outs();
    @(negedge clk);
    nReset = 1'b1;

    // basic sequence and immediate sign extension
    run1(10'b0100110011);
    run1(10'b0000001010);
    run1(10'b0000000111);
    run1(10'b1111111000);

    // HEI waiting for Handshake=1: long low phase, then held high
    repeat (20) hs_q.push_back(1'b0);
    hs_q.push_back(1'b1);
    run1(10'b1001000001);
    Handshake = 1'b0;

    // short glitch must not release; a later full-length pulse does
    repeat (5) hs_q.push_back(1'b0);
    repeat (DEB - 1) hs_q.push_back(1'b1);
    repeat (4) hs_q.push_back(1'b0);
    hs_q.push_back(1'b1);
    run1(10'b1001001001);
    Handshake = 1'b0;

    // HEI releasing on Handshake=0
    run1(10'b1101100100);
    run1(10'b0011110101);

    // reset mid-EXEC
    Instruction = 10'b0110110111;
    step(); step();
    check("pre_rst_exec", Stage, 2);
    do_reset();
    run1(10'b0100110011);

    // reset mid-WAIT
    Instruction = 10'b1001000001;
    Handshake = 1'b0;
    repeat (5) step();
    check("pre_rst_wait", {Stage, PCHold}, 3'b111);
    do_reset();
    run1(10'b0001011110);

    // random back-to-back non-HEI on both builds, starting aligned after reset
    do_reset();
    pc_a = 0;
    pc_b = 0;
    n_pair = 40;
    for (int i = 0; i < n_pair; i++) begin
      a = 10'($urandom);
      b = 12'($urandom);
      if (a[9] && a[6]) a[6] = 1'b0;
      if (b[11] && b[8]) b[8] = 1'b0;
      run_pair(a, b, pc_a, pc_b);
    end
    check("pcinc_count", pc_a, n_pair);
    check("pcinc_count_w", pc_b, n_pair);

    // random mix on the default build, including HEI with random Handshake activity
    for (int i = 0; i < 30; i++) begin
      a = 10'($urandom);
      Handshake = 1'($urandom);
      for (int j = 0; j < 12; j++) hs_q.push_back(1'($urandom));
      hs_q.push_back(a[0]);
      run1(a);
      hs_q.delete();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
